// File: rtl/ppu_oam_dma.sv
// ppu_oam_dma -- sprite DMA engine feeding the PPU's CPU register port.
//
// A CPU write to $4014 halts the CPU and copies page {cpu_wdata, 8'h00..8'hFF}
// from the CPU bus into OAMDATA ($2004), one byte per read/write CPU-cycle
// pair, with an optional alignment cycle so that every read lands on an even
// CPU cycle (513 or 514 halted CPU cycles in total).
//
// Ports:
//   CLK, RESET        system clock, asynchronous active-high reset
//   cpu_cycle_en      one-CLK strobe on the last CLK of each CPU cycle
//   cpu_addr/wdata/w  CPU bus write snoop (trigger on $4014)
//   cpu_halt          high while the DMA owns the bus
//   mem_addr/mem_rd   DMA source read request
//   mem_rdata         read data, valid at the cpu_cycle_en edge of a read cycle
//   ppu_addr/data/w   PPU register write port (OAMDATA during WRITE)
//   dma_done          one-CLK pulse as the transfer completes
module ppu_oam_dma (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_cycle_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_w,
  output logic        cpu_halt,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [2:0]  ppu_addr,
  output logic [7:0]  ppu_data,
  output logic        ppu_w,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic        done_q, done_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    parity_d = parity_q;
    // done is evaluated every CLK so the pulse lasts exactly one CLK even
    // when CPU cycles span several CLKs.
    done_d   = 1'b0;
    if (cpu_cycle_en) begin
      parity_d = ~parity_q;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_w && (cpu_addr == 16'h4014)) begin
            state_d = S_HALT;
            page_d  = cpu_wdata;
            idx_d   = 8'h00;
          end
        end
        // An odd halt cycle is already followed by an even one; an even halt
        // cycle needs one extra cycle so reads stay on even cycles.
        S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          data_d  = mem_rdata;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = S_IDLE;
            idx_d   = 8'h00;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign cpu_halt = (state_q != S_IDLE);
  assign mem_rd   = (state_q == S_READ);
  assign mem_addr = (state_q == S_READ) ? {page_q, idx_q} : 16'h0000;
  assign ppu_addr = (state_q == S_WRITE) ? 3'd4 : 3'd0;
  assign ppu_data = (state_q == S_WRITE) ? data_q : 8'h00;
  // Qualified with the enable so the PPU sees a single-CLK write per byte.
  assign ppu_w    = (state_q == S_WRITE) && cpu_cycle_en;
  assign dma_done = done_q;

endmodule

// File: tb/tb_ppu_oam_dma.sv
module tb_ppu_oam_dma;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_cycle_en = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_w = 1'b0;
  logic        cpu_halt;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [2:0]  ppu_addr;
  logic [7:0]  ppu_data;
  logic        ppu_w;
  logic        dma_done;

  ppu_oam_dma dut (
    .CLK(CLK), .RESET(RESET), .cpu_cycle_en(cpu_cycle_en),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_w(cpu_w),
    .cpu_halt(cpu_halt), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .ppu_addr(ppu_addr), .ppu_data(ppu_data),
    .ppu_w(ppu_w), .dma_done(dma_done)
  );

  always #5 CLK = ~CLK;

  // Memory returns the inverted low address byte.
  assign mem_rdata = ~mem_addr[7:0];

  int total = 0;
  int bad = 0;
  int en_period = 1;
  int en_cnt = 0;
  int cyc = 0;          // index of the CPU cycle in progress since reset
  int busy_end = 0;     // first CPU cycle index at which the model is idle again
  int exp_done = 0;
  int n_done = 0;
  int run = 0;
  int hclk = 0;
  logic prev_halt = 1'b0;

  logic [7:0]  wr_q[$];
  logic [15:0] rd_q[$];
  int          len_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // CPU-cycle enable generator.
  always @(posedge CLK) begin
    #1;
    en_cnt = en_cnt + 1;
    cpu_cycle_en = ((en_cnt % en_period) == 0);
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else if (cpu_cycle_en) cyc <= cyc + 1;
  end

  // Monitor / scoreboard.
  always @(negedge CLK) begin
    logic [7:0]  ed;
    logic [15:0] ea;
    int L, s, pos, ln;
    if (RESET) begin
      run = 0;
      hclk = 0;
      prev_halt = 1'b0;
    end else begin
      if (cpu_halt) hclk++;
      if (ppu_w) begin
        if (wr_q.size() == 0) chk("unexpected_ppu_w", 1, 0);
        else begin
          ed = wr_q.pop_front();
          chk("ppu_data", ppu_data, ed);
          chk("ppu_addr", ppu_addr, 4);
        end
      end
      if (cpu_cycle_en && mem_rd) begin
        if (rd_q.size() == 0) chk("unexpected_mem_rd", 1, 0);
        else begin
          ea = rd_q.pop_front();
          chk("mem_addr", mem_addr, ea);
        end
      end
      if (dma_done) begin
        n_done++;
        chk("done_halt_low", cpu_halt, 0);
        chk("done_after_halt", prev_halt, 1);
      end
      if (cpu_cycle_en) begin
        if (cpu_halt) begin
          run++;
          if (len_q.size() == 0) begin
            if (run == 1) chk("unexpected_halt", 1, 0);
          end else begin
            L = len_q[0];
            s = (L == 514) ? 2 : 1;
            pos = run;
            chk("rd_sched", mem_rd, ((pos > s) && (((pos - s) % 2) == 1)) ? 1 : 0);
            chk("wr_sched", ppu_w, ((pos > s) && (((pos - s) % 2) == 0)) ? 1 : 0);
          end
        end else if (run > 0) begin
          if (len_q.size() == 0) chk("halt_no_expect", run, 0);
          else begin
            ln = len_q.pop_front();
            chk("halt_cycles", run, ln);
            chk("halt_clks", hclk, ln * en_period);
          end
          run = 0;
          hclk = 0;
        end
      end
      prev_halt = cpu_halt;
    end
  end

  // One CPU write issued in a CPU cycle whose following cycle has parity
  // want_par (2 = don't care). The model queues a full transfer if idle.
  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input int want_par);
    bit ok;
    int L;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #2;
      if (cpu_cycle_en && (want_par == 2 || ((cyc + 1) % 2) == want_par)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("wr_slot_timeout", 0, 1);
      return;
    end
    cpu_addr = a; cpu_wdata = d; cpu_w = 1'b1;
    if (a == 16'h4014 && cyc >= busy_end) begin
      L = (((cyc + 1) % 2) == 1) ? 513 : 514;
      busy_end = cyc + L + 1;
      for (int n = 0; n < 256; n++) begin
        wr_q.push_back(~n[7:0]);
        rd_q.push_back({d, n[7:0]});
      end
      len_q.push_back(L);
      exp_done++;
    end
    @(posedge CLK); #2;
    cpu_w = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge CLK); #2;
      if (wr_q.size() == 0 && len_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (6) @(posedge CLK);
    #2;
  endtask

  task automatic wait_left(input int left);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #2;
      if (wr_q.size() <= left) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("progress_timeout", 0, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cpu_halt"}, cpu_halt, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_ppu_addr"}, ppu_addr, 0);
    chk({tag, "_ppu_data"}, ppu_data, 0);
    chk({tag, "_ppu_w"}, ppu_w, 0);
    chk({tag, "_dma_done"}, dma_done, 0);
  endtask

  initial begin
    logic [7:0] pg;
    // Reset with the enable running every CLK.
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    chk_quiet("reset");
    RESET = 1'b0;
    cpu_wr(16'h4000, 8'h55, 2);
    repeat (5) @(posedge CLK);
    #2;
    chk_quiet("wr4000");

    // Odd-aligned then even-aligned transfers from page 2.
    cpu_wr(16'h4014, 8'h02, 1);
    wait_idle();
    cpu_wr(16'h4014, 8'h02, 0);
    wait_idle();

    // Re-trigger at idx 10 is ignored.
    cpu_wr(16'h4014, 8'h02, $urandom_range(0, 1));
    wait_left(246);
    cpu_wr(16'h4014, 8'h07, 2);
    wait_idle();

    // Reset in the middle of a transfer (idx 100), then page 3.
    cpu_wr(16'h4014, 8'($urandom), $urandom_range(0, 1));
    wait_left(156);
    RESET = 1'b1;
    wr_q.delete();
    rd_q.delete();
    len_q.delete();
    exp_done--;
    busy_end = 0;
    #1;
    chk_quiet("midreset");
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    cpu_wr(16'h4014, 8'h03, $urandom_range(0, 1));
    wait_idle();

    // Slow enable, odd-aligned.
    en_period = 3;
    repeat (4) @(posedge CLK);
    cpu_wr(16'h4014, 8'($urandom), 1);
    wait_idle();

    // Random page, spacing, alignment and idle gap.
    for (int r = 0; r < 3; r++) begin
      en_period = $urandom_range(1, 4);
      pg = 8'($urandom);
      repeat ($urandom_range(1, 8)) @(posedge CLK);
      cpu_wr(16'h4014, pg, $urandom_range(0, 1));
      wait_idle();
    end

    chk("end_wr_q", wr_q.size(), 0);
    chk("end_rd_q", rd_q.size(), 0);
    chk("end_len_q", len_q.size(), 0);
    chk("done_count", n_done, exp_done);
    chk_quiet("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
